// File: rtl/lab09_led_counter_if.sv
// LED drive bundle for lab09_led_counter.
// The counter is the master and drives outputLed; the board/observer is the slave.
interface lab09_led_counter_if #(
  parameter int LED_W = 8
);
  logic [LED_W-1:0] outputLed;

  modport master (output outputLed);
  modport slave  (input  outputLed);
endinterface

// File: rtl/lab09_led_counter.sv
// lab09_led_counter: free-running ping-pong LED counter.
// A prescaler produces one tick every DIV clocks. On each tick the counter
// moves one step: it climbs to full scale, then falls back to 0, and repeats.
// Each end point is shown for exactly one step.
// The counter value drives the LED bank through one register stage.
// Optional build macro GRAY_OUT_EN: drive the LEDs with the Gray code of the
// count, so that exactly one LED toggles per step. Without it, the LEDs show
// plain binary.
module lab09_led_counter #(
  parameter int LED_W = 8,
  parameter int DIV   = 4
) (
  input  logic                clk,
  input  logic                rst,
  lab09_led_counter_if.master led_if
);

  localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [LED_W-1:0] CNT_MAX    = {LED_W{1'b1}};
  localparam logic [LED_W-1:0] CNT_ZERO   = {LED_W{1'b0}};
  localparam logic [LED_W-1:0] CNT_ONE    = LED_W'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PW-1:0]    presc_q, presc_d;
  logic [LED_W-1:0] cnt_q,   cnt_d;
  logic [LED_W-1:0] led_q;
  dir_e             dir_q,   dir_d;
  logic             tick_s;

  // Maps the count to the LED pattern: Gray code or plain binary.
  function automatic logic [LED_W-1:0] encode_led(input logic [LED_W-1:0] value);
`ifdef GRAY_OUT_EN
    return value ^ (value >> 1);
`else
    return value;
`endif
  endfunction

  // Next state: prescaler wrap/increment, and a counter/direction step only on a tick.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    tick_s  = (presc_q == PRESC_LAST);
    if (tick_s) begin
      presc_d = {PW{1'b0}};
      case (dir_q)
        DIR_UP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            dir_d = DIR_UP;
          end
        end
        DIR_DOWN: begin
          if (cnt_q == CNT_ZERO) begin
            cnt_d = cnt_q + CNT_ONE;
            dir_d = DIR_UP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
          end
        end
        default: begin
          cnt_d = CNT_ZERO;
          dir_d = DIR_UP;
        end
      endcase
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // State register. Synchronous reset has priority over any pending tick.
  // The LED register loads the next count, so it shows a new value on the same edge as the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= {PW{1'b0}};
      cnt_q   <= CNT_ZERO;
      dir_q   <= DIR_UP;
      led_q   <= CNT_ZERO;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      led_q   <= encode_led(cnt_d);
    end
  end

  assign led_if.outputLed = led_q;

endmodule

// File: tb/tb_lab09_led_counter.sv
// Testbench for lab09_led_counter: LED_W=4, with one instance at DIV=4 and one at DIV=1.
// The reference model derives the expected LED value from the number of
// clock edges since reset was released, using a triangle-wave formula.
module tb_lab09_led_counter;

  localparam int LED_W = 4;
  localparam int MAXV  = (1 << LED_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   edges;      // clock edges since reset was released (0 while in reset)
  int   prev_a;
  int   prev_b;

  lab09_led_counter_if #(.LED_W(LED_W)) if_a ();
  lab09_led_counter_if #(.LED_W(LED_W)) if_b ();

  lab09_led_counter #(.LED_W(LED_W), .DIV(4)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .led_if (if_a)
  );

  lab09_led_counter #(.LED_W(LED_W), .DIV(1)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .led_if (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each step is one tick; position in the 2*MAX-step period folded into a triangle.
  function automatic int model(input int e, input int div);
    int k;
    int m;
    int v;
    k = e / div;
    m = k % (2 * MAXV);
    v = (m <= MAXV) ? m : (2 * MAXV - m);
`ifdef GRAY_OUT_EN
    v = v ^ (v >> 1);
`endif
    return v;
  endfunction

  // One clock edge with rst driven at value r, then checks both instances at the falling edge.
  task automatic cycle(input logic r);
    int exp_a;
    int exp_b;
    int diff;
    rst = r;
    @(posedge clk);
    if (r) edges = 0;
    else   edges = edges + 1;
    @(negedge clk);
    exp_a = model(edges, 4);
    exp_b = model(edges, 1);
    checks = checks + 1;
    if ($isunknown(if_a.outputLed) || (int'(if_a.outputLed) !== exp_a)) begin
      errors = errors + 1;
      $display("FAIL led_div4 edge=%0d rst=%0b got=%0d exp=%0d", edges, r, if_a.outputLed, exp_a);
    end
    checks = checks + 1;
    if ($isunknown(if_b.outputLed) || (int'(if_b.outputLed) !== exp_b)) begin
      errors = errors + 1;
      $display("FAIL led_div1 edge=%0d rst=%0b got=%0d exp=%0d", edges, r, if_b.outputLed, exp_b);
    end
`ifdef GRAY_OUT_EN
    if (!r && (exp_a != prev_a)) begin
      diff = int'(if_a.outputLed) ^ prev_a;
      checks = checks + 1;
      if ($countones(diff) != 1) begin
        errors = errors + 1;
        $display("FAIL gray_one_toggle edge=%0d got_bits=%0d exp_bits=1", edges, $countones(diff));
      end
    end
`else
    diff = 0;
`endif
    prev_a = exp_a;
    prev_b = exp_b;
  endtask

  // Two reset edges read 0, and the first edge after release still reads 0.
  task automatic test_reset();
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    checks = checks + 1;
    if (if_a.outputLed !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL reset_release_edge1 got=%0d exp=0", if_a.outputLed);
    end
  endtask

  // Full climb and descent: 15 at edge 60, 14 at 64, 0 at 120, 1 at 124.
  task automatic test_sequence();
    int v;
    while (edges < 124) begin
      cycle(1'b0);
      if (edges == 60 || edges == 64 || edges == 120 || edges == 124) begin
        v = (edges == 60) ? 15 : (edges == 64) ? 14 : (edges == 120) ? 0 : 1;
`ifdef GRAY_OUT_EN
        v = v ^ (v >> 1);
`endif
        checks = checks + 1;
        if (int'(if_a.outputLed) !== v) begin
          errors = errors + 1;
          $display("FAIL landmark edge=%0d got=%0d exp=%0d", edges, if_a.outputLed, v);
        end
      end
    end
  endtask

  // Reset at edge 50 mid-climb; then 1 must reappear DIV edges after release.
  task automatic test_mid_reset();
    int one_v;
    cycle(1'b1);
    while (edges < 49) cycle(1'b0);
    cycle(1'b1);
    checks = checks + 1;
    if (if_a.outputLed !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL mid_reset got=%0d exp=0", if_a.outputLed);
    end
    while (edges < 4) cycle(1'b0);
    one_v = 1;
    checks = checks + 1;
    if (int'(if_a.outputLed) !== one_v) begin
      errors = errors + 1;
      $display("FAIL restart_first_step got=%0d exp=%0d", if_a.outputLed, one_v);
    end
  endtask

  // Randomly placed reset pulses over a long run, checked against the model each edge.
  task automatic test_random_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edges  = 0;
    prev_a = 0;
    prev_b = 0;
    rst    = 1'b1;
    test_reset();
    test_sequence();
    test_mid_reset();
    test_random_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
